// File: rtl/pixel_to_fifo_converter.sv
// Packs a serial valid/ready pixel stream into DATA_WIDTH-bit words for the 36-bit write-side
// FIFO. Pixel 0 of a word lands in the MSBs. A packet that ends mid-word is flushed
// zero-padded, and out_empty reports the number of unused pixel slots.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   in_*           pixel input stream (valid/ready, sop/eop sideband)
//   out_*          packed word output stream (valid/ready, sop/eop/empty sideband)
//   packet_count   words with out_eop consumed downstream, wraps at 16 bits
//   sop_error      sticky: in_sop accepted while a partial word was in progress
module pixel_to_fifo_converter #(
  parameter int unsigned PIXEL_WIDTH     = 9,
  parameter int unsigned PIXELS_PER_WORD = 4,
  parameter int unsigned DATA_WIDTH      = 36,
  parameter int unsigned EMPTY_WIDTH     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [PIXEL_WIDTH-1:0] in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic [15:0]            packet_count,
  output logic                   sop_error
);

  localparam int unsigned SlotW = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(PIXELS_PER_WORD - 1);

  logic [SlotW-1:0]       slot_q;
  logic [DATA_WIDTH-1:0]  asm_q;
  logic                   pend_sop_q;
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic                   out_sop_q;
  logic                   out_eop_q;
  logic [EMPTY_WIDTH-1:0] out_empty_q;
  logic [15:0]            packet_count_q;
  logic                   sop_error_q;

  logic                   in_accept;
  logic                   restart;
  logic [SlotW-1:0]       base_slot;
  logic [DATA_WIDTH-1:0]  word_d;
  logic                   word_done;
  logic                   word_sop;
  logic [EMPTY_WIDTH-1:0] word_empty;

  // The output register can take a new word whenever it is empty or being drained this cycle.
  assign in_ready = reset || !out_valid_q || out_ready;

  always_comb begin
    in_accept = in_valid && in_ready;
    // An SOP in the middle of a word abandons the partial word and restarts at slot 0.
    restart   = in_sop && (slot_q != '0);
    base_slot = restart ? '0 : slot_q;
    word_d    = restart ? '0 : asm_q;
    for (int unsigned s = 0; s < PIXELS_PER_WORD; s++) begin
      if (base_slot == SlotW'(s)) begin
        word_d[DATA_WIDTH-1-s*PIXEL_WIDTH -: PIXEL_WIDTH] = in_data;
      end
    end
    word_done  = (base_slot == LastSlot) || in_eop;
    word_sop   = pend_sop_q || in_sop;
    word_empty = EMPTY_WIDTH'(LastSlot - base_slot);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q         <= '0;
      asm_q          <= '0;
      pend_sop_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_sop_q      <= 1'b0;
      out_eop_q      <= 1'b0;
      out_empty_q    <= '0;
      packet_count_q <= '0;
      sop_error_q    <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        if (out_eop_q) begin
          packet_count_q <= packet_count_q + 16'd1;
        end
      end
      if (in_accept) begin
        if (restart) begin
          sop_error_q <= 1'b1;
        end
        if (word_done) begin
          // A load here overrides the consume above, so back-to-back words have no bubble.
          out_valid_q <= 1'b1;
          out_data_q  <= word_d;
          out_sop_q   <= word_sop;
          out_eop_q   <= in_eop;
          out_empty_q <= word_empty;
          slot_q      <= '0;
          asm_q       <= '0;
          pend_sop_q  <= 1'b0;
        end else begin
          asm_q      <= word_d;
          slot_q     <= base_slot + 1'b1;
          pend_sop_q <= word_sop;
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sop      = out_sop_q;
  assign out_eop      = out_eop_q;
  assign out_empty    = out_empty_q;
  assign packet_count = packet_count_q;
  assign sop_error    = sop_error_q;

endmodule

// File: tb/tb_pixel_to_fifo_converter.sv
// Directed bench for pixel_to_fifo_converter with a packet-level reference model checked every
// cycle, plus literal expectations on the words the DUT hands downstream.
module tb_pixel_to_fifo_converter;

  localparam int PW  = 9;
  localparam int PPW = 4;
  localparam int DW  = 36;
  localparam int EW  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_ready;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic [EW-1:0] out_empty;
  logic [15:0]   packet_count;
  logic          sop_error;

  pixel_to_fifo_converter #(
    .PIXEL_WIDTH    (PW),
    .PIXELS_PER_WORD(PPW),
    .DATA_WIDTH     (DW),
    .EMPTY_WIDTH    (EW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_ready    (in_ready),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_empty   (out_empty),
    .packet_count(packet_count),
    .sop_error   (sop_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixels of the word being assembled plus the word awaiting downstream.
  logic [PW-1:0] m_pix[$];
  bit            m_init = 0;
  bit            m_psop = 0;
  bit            m_valid = 0;
  bit            m_sop = 0;
  bit            m_eop = 0;
  bit            m_err = 0;
  logic [DW-1:0] m_data = '0;
  int            m_empty = 0;
  logic [15:0]   m_pcount = '0;

  task automatic model_step();
    bit acc;
    logic [DW-1:0] w;
    if (reset) begin
      m_pix.delete();
      m_psop   = 0;
      m_valid  = 0;
      m_pcount = '0;
      m_err    = 0;
      m_init   = 1;
      return;
    end
    if (!m_init) return;
    acc = in_valid && (!m_valid || out_ready);
    if (m_valid && out_ready) begin
      if (m_eop) m_pcount++;
      m_valid = 0;
    end
    if (acc) begin
      if (in_sop && m_pix.size() != 0) begin
        m_err = 1;
        m_pix.delete();
      end
      if (in_sop) m_psop = 1;
      m_pix.push_back(in_data);
      if (m_pix.size() == PPW || in_eop) begin
        w = '0;
        foreach (m_pix[i]) w |= DW'(m_pix[i]) << (DW - PW * (i + 1));
        m_data  = w;
        m_sop   = m_psop;
        m_eop   = in_eop;
        m_empty = PPW - m_pix.size();
        m_valid = 1;
        m_pix.delete();
        m_psop  = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } word_t;
  word_t got[$];

  // Per-cycle comparison; also logs each word the DUT hands off at the coming edge.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("in_ready", in_ready, reset ? 1'b1 : (!m_valid || out_ready));
      if (!reset) begin
        chk("out_valid", out_valid, m_valid);
        chk("packet_count", packet_count, m_pcount);
        chk("sop_error", sop_error, m_err);
        if (m_valid) begin
          chk("out_data", out_data, m_data);
          chk("out_sop", out_sop, m_sop);
          chk("out_eop", out_eop, m_eop);
          chk("out_empty", out_empty, m_empty);
        end
        if (out_valid && out_ready) got.push_back('{out_data, out_sop, out_eop, out_empty});
      end
    end
  end

  bit rnd_en = 0;
  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_en) out_ready = 1'($urandom_range(0, 1));
  end

  // Called at posedge+2; returns at posedge+2 just after the pixel has been accepted.
  task automatic send(input logic [PW-1:0] d, input logic s, input logic e);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      if (acc) break;
      if (n == 299) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: pixel 0x%0h not accepted, required within 300 cycles", d);
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!out_valid) done = 1;
      @(posedge clk);
      #2;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: out_valid still 1, required 0 within 100 cycles");
    end
  endtask

  task automatic send_4pix_packet();
    send(9'h041, 1'b1, 1'b0);
    send(9'h042, 1'b0, 1'b0);
    send(9'h043, 1'b0, 1'b0);
    send(9'h044, 1'b0, 1'b1);
  endtask

  task automatic check_after_reset(input string tag);
    int g;
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_pcount"}, packet_count, 16'd0);
    chk({tag, "_sop_error"}, sop_error, 1'b0);
    @(posedge clk);
    #2;
    g = got.size();
    send_4pix_packet();
    drain();
    chk({tag, "_words"}, got.size() - g, 1);
    chk({tag, "_data"}, got[got.size()-1].data, 36'h2_0908_8644);
    chk({tag, "_empty"}, got[got.size()-1].empty, 0);
    chk({tag, "_sopeop"}, {got[got.size()-1].sop, got[got.size()-1].eop}, 2'b11);
  endtask

  initial begin
    int g0;
    int npix;
    bit prev_eop;
    bit e;

    // Reset and reset state
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("in_ready_in_reset", in_ready, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 36'h0);
    chk("rst_sideband", {out_sop, out_eop, out_empty}, 4'b0000);
    chk("rst_pcount", packet_count, 16'd0);
    chk("rst_sop_error", sop_error, 1'b0);
    @(posedge clk);
    #2;

    // 8-pixel packet, two full words
    for (int i = 1; i <= 8; i++) send(PW'(i), i == 1, i == 8);
    drain();
    chk("t1_words", got.size(), 2);
    chk("t1_w0_data", got[0].data, 36'h0_0808_0604);
    chk("t1_w0_side", {got[0].sop, got[0].eop, got[0].empty}, 4'b1000);
    chk("t1_w1_data", got[1].data, 36'h0_2818_0E08);
    chk("t1_w1_side", {got[1].sop, got[1].eop, got[1].empty}, 4'b0100);
    chk("t1_pcount", packet_count, 16'd1);

    // 6-pixel packet: second word zero-padded, empty=2
    for (int i = 1; i <= 6; i++) send(PW'(i), i == 1, i == 6);
    drain();
    chk("t2_words", got.size(), 4);
    chk("t2_w1_data", got[3].data, 36'h0_2818_0000);
    chk("t2_w1_side", {got[3].sop, got[3].eop, got[3].empty}, 4'b0110);

    // Single-pixel packet
    send(9'h1FF, 1'b1, 1'b1);
    drain();
    chk("t3_data", got[4].data, 36'hF_F800_0000);
    chk("t3_side", {got[4].sop, got[4].eop, got[4].empty}, 4'b1111);
    chk("t3_pcount", packet_count, 16'd3);

    // Backpressure: word held stable, then random out_ready over 200 more pixels
    g0 = got.size();
    out_ready = 1'b0;
    send(9'h010, 1'b1, 1'b0);
    send(9'h011, 1'b0, 1'b0);
    send(9'h012, 1'b0, 1'b0);
    send(9'h013, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 9'h014;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("t4_hold_in_ready", in_ready, 1'b0);
      chk("t4_hold_data", out_data, 36'h0_8044_2413);
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rnd_en = 1;
    prev_eop = 0;
    for (int i = 1; i < 200; i++) begin
      e = (i == 199) || ($urandom_range(0, 6) == 0);
      send(PW'($urandom), prev_eop, e);
      prev_eop = e;
    end
    rnd_en = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    npix = 0;
    for (int i = g0; i < got.size(); i++) npix += PPW - int'(got[i].empty);
    chk("t4_pixel_total", npix, 204);

    // SOP on the 3rd pixel of a word
    g0 = got.size();
    send(9'h021, 1'b1, 1'b0);
    send(9'h022, 1'b0, 1'b0);
    send(9'h023, 1'b1, 1'b0);
    send(9'h024, 1'b0, 1'b0);
    send(9'h025, 1'b0, 1'b0);
    send(9'h026, 1'b0, 1'b1);
    drain();
    chk("t5_sop_error", sop_error, 1'b1);
    chk("t5_words", got.size() - g0, 1);
    chk("t5_data", got[got.size()-1].data, 36'h1_1890_4A26);
    chk("t5_side", {got[got.size()-1].sop, got[got.size()-1].eop, got[got.size()-1].empty},
        4'b1100);

    // Reset with a 2-pixel partial word in progress
    send(9'h031, 1'b1, 1'b0);
    send(9'h032, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    check_after_reset("t6a");

    // Reset with an unaccepted word held in the output register
    out_ready = 1'b0;
    send(9'h051, 1'b1, 1'b0);
    send(9'h052, 1'b0, 1'b0);
    send(9'h053, 1'b0, 1'b0);
    send(9'h054, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6b_held", out_valid, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    check_after_reset("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
